// File: rtl/csa_pipe.sv
// Pipelined carry-select adder/subtractor with valid/ready flow control.
// Each pipeline stage resolves WIDTH/STAGES result bits; pending operand bits ride along skewed.
module csa_pipe #(
    parameter int WIDTH  = 32,
    parameter int BLK    = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW = WIDTH / STAGES;
    localparam int NB = SW / BLK;

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // One global stall: a held output freezes the entire pipe, bubbles included.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    assign b_eff = sub ? ~b : b;
    assign c0    = sub ? ~cin : cin;

    genvar s, j;
    for (s = 0; s < STAGES; s++) begin : g_st
        localparam int HI = WIDTH - s * SW;

        logic [HI-1:0]         a_in;
        logic [HI-1:0]         bx_in;
        logic                  c_in;
        logic                  v_in;
        logic [SW-1:0]         sl_sum;
        logic [NB:0]           bc;
        logic [(s+1)*SW-1:0]   sum_d;
        logic [(s+1)*SW-1:0]   sum_q;
        logic                  vld_q;
        logic                  c_q;

        if (s == 0) begin : g_first
            assign a_in  = a;
            assign bx_in = b_eff;
            assign c_in  = c0;
            assign v_in  = in_valid;
            assign sum_d = sl_sum;
        end else begin : g_next
            assign a_in  = g_st[s-1].g_mid.a_q;
            assign bx_in = g_st[s-1].g_mid.bx_q;
            assign c_in  = g_st[s-1].c_q;
            assign v_in  = g_st[s-1].vld_q;
            assign sum_d = {sl_sum, g_st[s-1].sum_q};
        end

        assign bc[0] = c_in;

        for (j = 0; j < NB; j++) begin : g_blk
            logic [BLK:0] r0;
            logic [BLK:0] r1;

            assign r0 = {1'b0, a_in[j*BLK +: BLK]} + {1'b0, bx_in[j*BLK +: BLK]};
            assign r1 = {1'b0, a_in[j*BLK +: BLK]} + {1'b0, bx_in[j*BLK +: BLK]}
                      + {{BLK{1'b0}}, 1'b1};

            assign sl_sum[j*BLK +: BLK] = bc[j] ? r1[BLK-1:0] : r0[BLK-1:0];
            assign bc[j+1]              = bc[j] ? r1[BLK]     : r0[BLK];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (advance) begin
                vld_q <= v_in;
                c_q   <= bc[NB];
                sum_q <= sum_d;
            end
        end

        if (s < STAGES - 1) begin : g_mid
            logic [HI-SW-1:0] a_q;
            logic [HI-SW-1:0] bx_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q  <= '0;
                    bx_q <= '0;
                end else if (advance) begin
                    a_q  <= a_in[HI-1:SW];
                    bx_q <= bx_in[HI-1:SW];
                end
            end
        end else begin : g_last
            logic ovf_q;

            // Carry into the MSB is recovered as a ^ b' ^ sum at that bit.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= a_in[HI-1] ^ bx_in[HI-1] ^ sl_sum[SW-1] ^ bc[NB];
                end
            end
        end
    end

    assign out_valid = g_st[STAGES-1].vld_q;
    assign sum       = g_st[STAGES-1].sum_q;
    assign cout      = g_st[STAGES-1].c_q;
    assign ovf       = g_st[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_csa_pipe.sv
// Bench for csa_pipe (16-bit, 4-bit blocks, 2 stages): directed vectors plus a
// queue-based arithmetic model checked on every output cycle.
module tb_csa_pipe;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int errors = 0;
    int checks = 0;

    logic [17:0] q[$];
    logic        prev_stall = 1'b0;
    logic [17:0] prev_o;

    csa_pipe #(.WIDTH(W), .BLK(4), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Arithmetic reference: {ovf, cout, sum} from integer add/subtract.
    function automatic logic [17:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mcin, input logic msub);
        int u, sg;
        int ua, ub, sa, sb, c;
        logic [17:0] r;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        c  = int'(mcin);
        if (!msub) begin
            u  = ua + ub + c;
            sg = sa + sb + c;
        end else begin
            u  = ua + 65536 - ub - c;
            sg = sa - sb - c;
        end
        r[15:0] = u[15:0];
        r[16]   = (u >= 65536);
        r[17]   = (sg > 32767) || (sg < -32768);
        return r;
    endfunction

    // Scoreboard: outputs checked at negedge; transfers there complete at the next posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("hold", {13'd0, ovf, cout, sum, out_valid}, {13'd0, prev_o, 1'b1});
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out", {31'd0, out_valid}, 32'd0);
                end else begin
                    chk("sb_sum",  {16'd0, sum},  {16'd0, q[0][15:0]});
                    chk("sb_cout", {31'd0, cout}, {31'd0, q[0][16]});
                    chk("sb_ovf",  {31'd0, ovf},  {31'd0, q[0][17]});
                    if (out_ready) void'(q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_o     = {ovf, cout, sum};
            if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input logic ts);
        logic got;
        int   n;
        a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk) got = in_ready;
            @(posedge clk) #1;
            n++;
        end
        if (!got) chk("send_timeout", 32'd1, 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic t_lit(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tc, input logic ts,
                         input logic [W-1:0] es, input logic ec, input logic eo);
        chk({nm, "_model"}, {14'd0, model(ta, tb_, tc, ts)}, {14'd0, eo, ec, es});
        a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
        @(posedge clk) #1;
        in_valid = 1'b0;
        chk({nm, "_early"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk) #1;
        chk({nm, "_vld"},  {31'd0, out_valid}, 32'd1);
        chk({nm, "_sum"},  {16'd0, sum}, {16'd0, es});
        chk({nm, "_cout"}, {31'd0, cout}, {31'd0, ec});
        chk({nm, "_ovf"},  {31'd0, ovf}, {31'd0, eo});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum",       {16'd0, sum}, 32'd0);
        chk("rst_cout",      {31'd0, cout}, 32'd0);
        chk("rst_ovf",       {31'd0, ovf}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk) #1;

        // Basic adds and full carry ripple
        t_lit("zero",   16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        t_lit("ffff2",  16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0);
        t_lit("ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        // Overflow and subtract
        t_lit("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        t_lit("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        t_lit("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        t_lit("sub_bin", 16'h0009, 16'h0003, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0);
        @(posedge clk) #1;

        // Throughput: 8 back-to-back, valid on cycles 2..9
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                a = W'($urandom); b = W'($urandom);
                cin = 1'($urandom); sub = 1'($urandom); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk) #1;
            chk("thru_vld", {31'd0, out_valid}, {31'd0, (k >= 1 && k <= 8)});
        end
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: stall 3 cycles with a result presented
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        send(16'h4000, 16'h4000, 1'b0, 1'b0);
        chk("bp_vld", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b0;
        fork
            send(16'h0100, 16'h0200, 1'b1, 1'b1);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
                    chk("bp_out_vld",  {31'd0, out_valid}, 32'd1);
                end
                @(posedge clk) #1;
                out_ready = 1'b1;
            end
        join
        send(16'hABCD, 16'h1234, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;

        // Bubbles: in_valid 1,0,1 -> out_valid 1,0,1
        a = 16'h0F0F; b = 16'h00F1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk) #1;
        in_valid = 1'b0;
        @(posedge clk) #1;
        chk("bub_v0", {31'd0, out_valid}, 32'd1);
        a = 16'h8001; b = 16'h8001; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk) #1;
        in_valid = 1'b0;
        chk("bub_v1", {31'd0, out_valid}, 32'd0);
        @(posedge clk) #1;
        chk("bub_v2", {31'd0, out_valid}, 32'd1);
        repeat (2) @(posedge clk);
        #1;

        // Reset with transactions in flight
        send(16'h1234, 16'h1111, 1'b0, 1'b0);
        send(16'h5555, 16'h0101, 1'b0, 1'b1);
        chk("pre_rst_vld", {31'd0, out_valid}, 32'd1);
        chk("pre_rst_sum", {16'd0, sum}, 32'h2345);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld",  {31'd0, out_valid}, 32'd0);
        chk("arst_sum",  {16'd0, sum}, 32'd0);
        chk("arst_cout", {31'd0, cout}, 32'd0);
        chk("arst_ovf",  {31'd0, ovf}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk) #1;
            chk("no_stale", {31'd0, out_valid}, 32'd0);
        end
        t_lit("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

        for (int n = 0; n < 20 && q.size() != 0; n++) @(posedge clk);
        @(negedge clk);
        chk("drain", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
